// File: rtl/apb2axi_pkg.sv
// -----------------------------------------------------------------------------
// apb2axi_pkg
// Shared constants and types for the APB-to-AXI bridge.
//   REQ_WIDTH   : width of one request FIFO entry
//   AXI_ID_W    : AXI ID width; the shared ID pool holds 2**AXI_ID_W IDs
//   MAX_WR_OST  : default limit on outstanding writes
//   MAX_RD_OST  : default limit on outstanding reads
//   dir_e       : transfer direction tag stored per busy ID
// -----------------------------------------------------------------------------
package apb2axi_pkg;

    localparam int REQ_WIDTH  = 32;
    localparam int AXI_ID_W   = 4;
    localparam int MAX_WR_OST = 8;
    localparam int MAX_RD_OST = 8;

    typedef enum logic {
        DIR_RD = 1'b0,
        DIR_WR = 1'b1
    } dir_e;

endpackage

// File: rtl/apb2axi_id_pool.sv
// -----------------------------------------------------------------------------
// apb2axi_id_pool
// Shared AXI ID pool: a busy bit and a direction bit per ID.
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   alloc_en / alloc_dir      : take the lowest free ID for the given direction
//   free_avail / alloc_id     : some ID is free in the registered vector / which
//   wr_cpl_* / rd_cpl_*       : completion notifications per direction
//   wr_cpl_ok / rd_cpl_ok     : completion matches a busy ID of that direction
//   pool_empty                : registered, no ID left free
//   cpl_err                   : registered one-cycle pulse on a bogus completion
// -----------------------------------------------------------------------------
module apb2axi_id_pool #(
    parameter int AXI_ID_W = apb2axi_pkg::AXI_ID_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alloc_en,
    input  logic                alloc_dir,
    output logic                free_avail,
    output logic [AXI_ID_W-1:0] alloc_id,
    input  logic                wr_cpl_valid,
    input  logic [AXI_ID_W-1:0] wr_cpl_id,
    input  logic                rd_cpl_valid,
    input  logic [AXI_ID_W-1:0] rd_cpl_id,
    output logic                wr_cpl_ok,
    output logic                rd_cpl_ok,
    output logic                pool_empty,
    output logic                cpl_err
);
    import apb2axi_pkg::*;

    localparam int NUM_IDS = 1 << AXI_ID_W;

    logic [NUM_IDS-1:0] busy_q, busy_d;
    logic [NUM_IDS-1:0] dir_q, dir_d;
    logic               pool_empty_q, pool_empty_d;
    logic               cpl_err_q, cpl_err_d;

    // Lowest-index free ID; scanning downwards lets the lowest index win.
    always_comb begin
        alloc_id = {AXI_ID_W{1'b0}};
        for (int i = NUM_IDS - 1; i >= 0; i--) begin
            alloc_id = (!busy_q[i]) ? AXI_ID_W'(i) : alloc_id;
        end
    end

    assign free_avail = ~(&busy_q);

    // A completion is legitimate only for an ID busy in the same direction.
    assign wr_cpl_ok = wr_cpl_valid & busy_q[wr_cpl_id] & (dir_q[wr_cpl_id] == DIR_WR);
    assign rd_cpl_ok = rd_cpl_valid & busy_q[rd_cpl_id] & (dir_q[rd_cpl_id] == DIR_RD);

    // Next busy/dir vectors. The allocated ID is free in busy_q while any
    // legitimately completed ID is busy there, so the updates never collide.
    always_comb begin
        busy_d = busy_q;
        dir_d  = dir_q;
        busy_d[alloc_id]  = busy_q[alloc_id] | alloc_en;
        dir_d[alloc_id]   = alloc_en ? alloc_dir : dir_q[alloc_id];
        busy_d[wr_cpl_id] = busy_d[wr_cpl_id] & ~wr_cpl_ok;
        busy_d[rd_cpl_id] = busy_d[rd_cpl_id] & ~rd_cpl_ok;
        pool_empty_d = &busy_d;
        cpl_err_d    = (wr_cpl_valid & ~wr_cpl_ok) | (rd_cpl_valid & ~rd_cpl_ok);
    end

    // Pool state and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q       <= {NUM_IDS{1'b0}};
            dir_q        <= {NUM_IDS{1'b0}};
            pool_empty_q <= 1'b0;
            cpl_err_q    <= 1'b0;
        end else begin
            busy_q       <= busy_d;
            dir_q        <= dir_d;
            pool_empty_q <= pool_empty_d;
            cpl_err_q    <= cpl_err_d;
        end
    end

    assign pool_empty = pool_empty_q;
    assign cpl_err    = cpl_err_q;

endmodule

// File: rtl/apb2axi_issue_sched.sv
// -----------------------------------------------------------------------------
// apb2axi_issue_sched
// Issues requests from the WR/RD request FIFOs to the write/read builders,
// tagging each with an AXI ID from a pool shared by both directions.
// Ports:
//   aclk, areset                       : clock, asynchronous active-high reset
//   wr_in_* / rd_in_*                  : FIFO pop side (ready = grant, comb)
//   wr_out_* / rd_out_*                : registered stage towards the builders
//   wr_cpl_* / rd_cpl_*                : completions that release IDs
//   wr_ost_cnt / rd_ost_cnt            : outstanding transactions per direction
//   id_pool_empty                      : registered, no free ID
//   cpl_err                            : pulse on completion of a non-busy ID
// -----------------------------------------------------------------------------
module apb2axi_issue_sched #(
    parameter  int FIFO_ENTRY_W = apb2axi_pkg::REQ_WIDTH,
    parameter  int AXI_ID_W     = apb2axi_pkg::AXI_ID_W,
    parameter  int MAX_WR_OST   = apb2axi_pkg::MAX_WR_OST,
    parameter  int MAX_RD_OST   = apb2axi_pkg::MAX_RD_OST,
    localparam int WR_CNT_W     = $clog2(MAX_WR_OST + 1),
    localparam int RD_CNT_W     = $clog2(MAX_RD_OST + 1)
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    wr_in_valid,
    output logic                    wr_in_ready,
    input  logic [FIFO_ENTRY_W-1:0] wr_in_data,
    input  logic                    rd_in_valid,
    output logic                    rd_in_ready,
    input  logic [FIFO_ENTRY_W-1:0] rd_in_data,
    output logic                    wr_out_valid,
    input  logic                    wr_out_ready,
    output logic [FIFO_ENTRY_W-1:0] wr_out_data,
    output logic [AXI_ID_W-1:0]     wr_out_id,
    output logic                    rd_out_valid,
    input  logic                    rd_out_ready,
    output logic [FIFO_ENTRY_W-1:0] rd_out_data,
    output logic [AXI_ID_W-1:0]     rd_out_id,
    input  logic                    wr_cpl_valid,
    input  logic [AXI_ID_W-1:0]     wr_cpl_id,
    input  logic                    rd_cpl_valid,
    input  logic [AXI_ID_W-1:0]     rd_cpl_id,
    output logic [WR_CNT_W-1:0]     wr_ost_cnt,
    output logic [RD_CNT_W-1:0]     rd_ost_cnt,
    output logic                    id_pool_empty,
    output logic                    cpl_err
);
    import apb2axi_pkg::*;

    dir_e                    rr_q, rr_d;
    logic [WR_CNT_W-1:0]     wr_ost_cnt_q, wr_ost_cnt_d;
    logic [RD_CNT_W-1:0]     rd_ost_cnt_q, rd_ost_cnt_d;
    logic                    wr_out_valid_q, wr_out_valid_d;
    logic [FIFO_ENTRY_W-1:0] wr_out_data_q, wr_out_data_d;
    logic [AXI_ID_W-1:0]     wr_out_id_q, wr_out_id_d;
    logic                    rd_out_valid_q, rd_out_valid_d;
    logic [FIFO_ENTRY_W-1:0] rd_out_data_q, rd_out_data_d;
    logic [AXI_ID_W-1:0]     rd_out_id_q, rd_out_id_d;

    logic                    free_avail;
    logic [AXI_ID_W-1:0]     alloc_id;
    logic                    wr_cpl_ok, rd_cpl_ok;
    logic                    wr_open, rd_open, wr_elig, rd_elig;
    logic                    grant_wr, grant_rd;

    apb2axi_id_pool #(
        .AXI_ID_W (AXI_ID_W)
    ) u_id_pool (
        .clk          (aclk),
        .rst          (areset),
        .alloc_en     (grant_wr | grant_rd),
        .alloc_dir    (grant_wr),
        .free_avail   (free_avail),
        .alloc_id     (alloc_id),
        .wr_cpl_valid (wr_cpl_valid),
        .wr_cpl_id    (wr_cpl_id),
        .rd_cpl_valid (rd_cpl_valid),
        .rd_cpl_id    (rd_cpl_id),
        .wr_cpl_ok    (wr_cpl_ok),
        .rd_cpl_ok    (rd_cpl_ok),
        .pool_empty   (id_pool_empty),
        .cpl_err      (cpl_err)
    );

    // A stage can take a new request if it is empty or draining this cycle.
    assign wr_open = ~wr_out_valid_q | wr_out_ready;
    assign rd_open = ~rd_out_valid_q | rd_out_ready;
    assign wr_elig = wr_in_valid & wr_open & (wr_ost_cnt_q < WR_CNT_W'(MAX_WR_OST)) & free_avail;
    assign rd_elig = rd_in_valid & rd_open & (rd_ost_cnt_q < RD_CNT_W'(MAX_RD_OST)) & free_avail;

    // Single grant per cycle; the rr pointer only matters under contention.
    always_comb begin
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        rr_d     = rr_q;
        if (wr_elig && rd_elig) begin
            grant_wr = (rr_q == DIR_WR);
            grant_rd = (rr_q == DIR_RD);
        end else begin
            grant_wr = wr_elig;
            grant_rd = rd_elig;
        end
        if (grant_wr) begin
            rr_d = DIR_RD;
        end else if (grant_rd) begin
            rr_d = DIR_WR;
        end else begin
            rr_d = rr_q;
        end
    end

    assign wr_in_ready = grant_wr;
    assign rd_in_ready = grant_rd;

    // Outstanding counters: a grant and a legitimate completion cancel out.
    always_comb begin
        wr_ost_cnt_d = wr_ost_cnt_q + WR_CNT_W'(grant_wr) - WR_CNT_W'(wr_cpl_ok);
        rd_ost_cnt_d = rd_ost_cnt_q + RD_CNT_W'(grant_rd) - RD_CNT_W'(rd_cpl_ok);
    end

    // Output stages: load on grant, clear valid on handshake, else hold.
    always_comb begin
        wr_out_valid_d = wr_out_valid_q;
        wr_out_data_d  = wr_out_data_q;
        wr_out_id_d    = wr_out_id_q;
        rd_out_valid_d = rd_out_valid_q;
        rd_out_data_d  = rd_out_data_q;
        rd_out_id_d    = rd_out_id_q;
        if (grant_wr) begin
            wr_out_valid_d = 1'b1;
            wr_out_data_d  = wr_in_data;
            wr_out_id_d    = alloc_id;
        end else if (wr_out_ready) begin
            wr_out_valid_d = 1'b0;
        end else begin
            wr_out_valid_d = wr_out_valid_q;
        end
        if (grant_rd) begin
            rd_out_valid_d = 1'b1;
            rd_out_data_d  = rd_in_data;
            rd_out_id_d    = alloc_id;
        end else if (rd_out_ready) begin
            rd_out_valid_d = 1'b0;
        end else begin
            rd_out_valid_d = rd_out_valid_q;
        end
    end

    // Scheduler state registers.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rr_q           <= DIR_WR;
            wr_ost_cnt_q   <= {WR_CNT_W{1'b0}};
            rd_ost_cnt_q   <= {RD_CNT_W{1'b0}};
            wr_out_valid_q <= 1'b0;
            wr_out_data_q  <= {FIFO_ENTRY_W{1'b0}};
            wr_out_id_q    <= {AXI_ID_W{1'b0}};
            rd_out_valid_q <= 1'b0;
            rd_out_data_q  <= {FIFO_ENTRY_W{1'b0}};
            rd_out_id_q    <= {AXI_ID_W{1'b0}};
        end else begin
            rr_q           <= rr_d;
            wr_ost_cnt_q   <= wr_ost_cnt_d;
            rd_ost_cnt_q   <= rd_ost_cnt_d;
            wr_out_valid_q <= wr_out_valid_d;
            wr_out_data_q  <= wr_out_data_d;
            wr_out_id_q    <= wr_out_id_d;
            rd_out_valid_q <= rd_out_valid_d;
            rd_out_data_q  <= rd_out_data_d;
            rd_out_id_q    <= rd_out_id_d;
        end
    end

    assign wr_out_valid = wr_out_valid_q;
    assign wr_out_data  = wr_out_data_q;
    assign wr_out_id    = wr_out_id_q;
    assign rd_out_valid = rd_out_valid_q;
    assign rd_out_data  = rd_out_data_q;
    assign rd_out_id    = rd_out_id_q;
    assign wr_ost_cnt   = wr_ost_cnt_q;
    assign rd_ost_cnt   = rd_ost_cnt_q;

endmodule

// File: doc/apb2axi_issue_sched.md
Name: apb2axi_issue_sched

Overview:
- Issue scheduler between the WR/RD request FIFOs and the write/read builders.
- Shares one AXI ID pool (2**AXI_ID_W IDs) between both directions.
- Enforces per-direction outstanding-transaction limits and round-robins when both FIFOs compete for the pool.
- Frees IDs on completion notifications from the response collector.

Parameters:
- FIFO_ENTRY_W, REQ_WIDTH, width of a request FIFO entry (passed through untouched)
- AXI_ID_W, 4, AXI ID width; pool size NUM_IDS = 2**AXI_ID_W
- MAX_WR_OST, 8, maximum outstanding writes (1..NUM_IDS)
- MAX_RD_OST, 8, maximum outstanding reads (1..NUM_IDS)

Ports:
- aclk  in  1  single clock
- areset  in  1  asynchronous, active-high reset
- wr_in_valid / wr_in_ready / wr_in_data  in/out/in  1/1/FIFO_ENTRY_W  write-FIFO pop side
- rd_in_valid / rd_in_ready / rd_in_data  in/out/in  1/1/FIFO_ENTRY_W  read-FIFO pop side
- wr_out_valid / wr_out_ready  out/in  1/1  to write builder
- wr_out_data / wr_out_id  out/out  FIFO_ENTRY_W/AXI_ID_W  to write builder
- rd_out_valid / rd_out_ready  out/in  1/1  to read builder
- rd_out_data / rd_out_id  out/out  FIFO_ENTRY_W/AXI_ID_W  to read builder
- wr_cpl_valid / wr_cpl_id  in  1/AXI_ID_W  B-channel completion (BVALID&BREADY)
- rd_cpl_valid / rd_cpl_id  in  1/AXI_ID_W  R-channel final beat (RLAST&RVALID&RREADY)
- wr_ost_cnt  out  $clog2(MAX_WR_OST+1)  outstanding writes
- rd_ost_cnt  out  $clog2(MAX_RD_OST+1)  outstanding reads
- id_pool_empty  out  1  no free ID (registered)
- cpl_err  out  1  one-cycle pulse: completion for an ID not busy in that direction

Behaviour:
- One clock aclk; reset areset is asynchronous and active-high.
- Reset values:
  - all IDs free, dir bits 0
  - wr/rd_ost_cnt=0, id_pool_empty=0, cpl_err=0
  - *_out_valid=0, *_out_data/id=0
  - rr pointer = WRITE
- State per ID: busy bit + dir bit (1=write).
- Output stage per direction: one register (valid/data/id).
  - Stage is "open" when !out_valid, or when out_valid&out_ready this cycle.
- Eligibility for direction X:
  - X_in_valid, AND
  - X stage open, AND
  - X_ost_cnt < MAX_X_OST, AND
  - at least one free ID in the registered busy vector.
- Grant, at most one per cycle:
  - Only one eligible: that direction is granted.
  - Both eligible: rr pointer decides; after any grant the pointer moves to the other direction.
  - X_in_ready is combinational and equals grant_X. No ready without grant, so no FIFO data is lost.
- On the grant edge:
  - allocate lowest-index free ID
  - set busy, set dir = X
  - X_ost_cnt += 1
  - X_out_valid=1, X_out_data=X_in_data, X_out_id=ID
- Latency: grant to out_valid is 1 cycle. Back-to-back grants in the same direction are possible when out_ready=1.
- out_valid held with data/id stable until out_ready.
- Completion for X with busy[id]=1 and dir[id]=X:
  - clear busy
  - X_ost_cnt -= 1
  - the freed ID is reusable from the next cycle (allocation uses the pre-update vector)
- Completion for a non-busy ID or wrong direction: ignored (no state change), cpl_err=1 for one cycle.
- Simultaneous events:
  - wr and rd completions in the same cycle are both processed; their IDs necessarily differ when both are legitimate.
  - Grant and completion in the same direction, same cycle: count unchanged net.
- Pool exhaustion: id_pool_empty=1 the cycle after the last free ID is taken. Clears the cycle after a completion frees one.
- Counters never exceed MAX or go below 0. A completion with count 0 is always the error case.
- Reset mid-operation: all state cleared immediately. In-flight IDs are forgotten; a later completion for them gives cpl_err.

Decomposition:
- apb2axi_pkg additions:
  - REQ_WIDTH (existing)
  - AXI_ID_W
  - MAX_WR_OST / MAX_RD_OST defaults
  - enum dir_e {DIR_RD=0, DIR_WR=1}
- One sub-module: apb2axi_id_pool.
  - Contents: busy/dir vectors, lowest-free priority encoder, alloc/free ports, error detect.
- Arbitration, counters and output stages stay in the top of this block.

Test Plan:
- Single write, out_ready=1:
  - wr_in_valid one cycle → wr_in_ready same cycle; next cycle wr_out_valid=1, wr_out_id=0, wr_ost_cnt=1.
  - wr_cpl_id=0 → wr_ost_cnt=0.
- Both FIFOs valid continuously, no completions:
  - grants alternate W,R,W,R…
  - IDs 0,1,2,… in grant order
  - each count saturates at 8, and issue stops there.
- MAX_WR_OST=2, writes only:
  - third write held with wr_in_ready=0
  - wr_cpl_id=1 → third write issued next cycle with ID 1.
- NUM_IDS=4, fill with 2 writes + 2 reads:
  - id_pool_empty=1; further requests stall.
  - rd_cpl_id=2 → pool frees; next grant gets ID 2.
- wr_out_ready=0 for 5 cycles:
  - wr_out_valid/data/id stable
  - only read grants proceed
  - write issues resume the cycle after ready rises.
- Completion errors:
  - rd_cpl_id=3 while ID 3 is busy as write → cpl_err pulse, counts unchanged.
  - Assert areset mid-traffic → all outputs return to reset values asynchronously.
